// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vend_pkg
// Brief   : Shared state encoding and coin unit constants for vend_controller.
// Revision: 1.0
// ============================================================================
package vend_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t CREDIT = 2'd1;
    localparam state_t VEND   = 2'd2;
    localparam state_t CHANGE = 2'd3;

    localparam logic [1:0] UNIT_FIFTY  = 2'd1;
    localparam logic [1:0] UNIT_DOLLAR = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vend_timer.sv
`default_nettype none
// ============================================================================
// Module  : vend_timer
// Brief   : Loadable down-counter; expired is high while the count is zero.
// Revision: 1.0
// ============================================================================
module vend_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module  : vend_controller
// Brief   : Multi-item vending sequencer: credit, selection, dispense, change.
//           Define VEND_WDOG_EN to add the dispense_ack watchdog.
// Revision: 1.0
// ============================================================================
module vend_controller
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS   = 4,
    parameter int CREDIT_W    = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int WDOG_CYC    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fifty,
    input  logic                            dollar,
    input  logic                            cancel,
    input  logic                            sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0]    sel_idx,
    input  logic [NUM_ITEMS*CREDIT_W-1:0]   price_tbl,
    input  logic [NUM_ITEMS-1:0]            sold_out,
    input  logic                            dispense_ack,
    output logic [CREDIT_W-1:0]             credit,
    output logic                            insert_coin,
    output logic                            dispense_req,
    output logic [$clog2(NUM_ITEMS)-1:0]    dispense_idx,
    output logic                            coin_out,
    output logic                            coin_reject,
    output logic                            err_soldout,
    output logic                            err_funds,
    output logic                            fault
);

    localparam int IDX_W = $clog2(NUM_ITEMS);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    state_t              r_state, w_state_next;
    logic [CREDIT_W-1:0] r_credit, w_credit_next;
    logic [IDX_W-1:0]    r_idx, w_idx_next;
    logic                r_phase, w_phase_next;
    logic                r_coin_out, r_reject, r_soldout, r_funds, r_fault;
    logic                w_coin_out, w_reject, w_soldout, w_funds, w_fault;
    logic                w_tmo_load, w_tmo_expired, w_wdog_expired;
    logic                w_coin;
    logic [2:0]          w_units;
    logic [CREDIT_W:0]   w_coin_sum;
    logic [CREDIT_W-1:0] w_sel_price, w_refund_credit;

    assign w_coin      = fifty | dollar;
    assign w_units     = {1'b0, (fifty ? UNIT_FIFTY : 2'd0)} + {1'b0, (dollar ? UNIT_DOLLAR : 2'd0)};
    // The carry bit of the sum flags an overflow past the maximum credit.
    assign w_coin_sum  = {1'b0, r_credit} + (CREDIT_W+1)'(w_units);
    assign w_sel_price = price_tbl[sel_idx*CREDIT_W +: CREDIT_W];

    vend_timer #(.WIDTH(TMO_W)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmo_load),
        .load_val (TMO_LOAD),
        .en       (r_state == CREDIT),
        .expired  (w_tmo_expired)
    );

`ifdef VEND_WDOG_EN
    localparam int WDG_W = $clog2(WDOG_CYC + 1);
    localparam logic [WDG_W-1:0] WDG_LOAD = WDG_W'(WDOG_CYC - 1);

    logic                w_vend_entry;
    logic [CREDIT_W-1:0] w_vend_price;
    logic [CREDIT_W:0]   w_refund_sum;

    assign w_vend_entry    = (w_state_next == VEND) && (r_state != VEND);
    assign w_vend_price    = price_tbl[r_idx*CREDIT_W +: CREDIT_W];
    assign w_refund_sum    = {1'b0, r_credit} + {1'b0, w_vend_price};
    assign w_refund_credit = w_refund_sum[CREDIT_W] ? '1 : w_refund_sum[CREDIT_W-1:0];

    vend_timer #(.WIDTH(WDG_W)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .load     (w_vend_entry),
        .load_val (WDG_LOAD),
        .en       (r_state == VEND),
        .expired  (w_wdog_expired)
    );
`else
    assign w_wdog_expired  = 1'b0;
    assign w_refund_credit = r_credit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_credit   <= '0;
            r_idx      <= '0;
            r_phase    <= 1'b0;
            r_coin_out <= 1'b0;
            r_reject   <= 1'b0;
            r_soldout  <= 1'b0;
            r_funds    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_credit   <= w_credit_next;
            r_idx      <= w_idx_next;
            r_phase    <= w_phase_next;
            r_coin_out <= w_coin_out;
            r_reject   <= w_reject;
            r_soldout  <= w_soldout;
            r_funds    <= w_funds;
            r_fault    <= w_fault;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_credit_next = r_credit;
        w_idx_next    = r_idx;
        w_phase_next  = 1'b0;
        w_coin_out    = 1'b0;
        w_reject      = 1'b0;
        w_soldout     = 1'b0;
        w_funds       = 1'b0;
        w_fault       = 1'b0;
        w_tmo_load    = 1'b0;
        case (r_state)
            IDLE, CREDIT: begin
                if (w_coin) begin
                    if (w_coin_sum[CREDIT_W]) begin
                        w_reject = 1'b1;
                    end else begin
                        w_credit_next = w_coin_sum[CREDIT_W-1:0];
                        w_state_next  = CREDIT;
                        w_tmo_load    = 1'b1;
                    end
                end else if (cancel) begin
                    if (r_state == CREDIT) begin
                        w_state_next = (r_credit == '0) ? IDLE : CHANGE;
                    end
                end else if (sel_valid) begin
                    if (sold_out[sel_idx]) begin
                        w_soldout  = 1'b1;
                        w_tmo_load = 1'b1;
                    end else if (r_credit < w_sel_price) begin
                        w_funds    = 1'b1;
                        w_tmo_load = 1'b1;
                    end else begin
                        w_credit_next = r_credit - w_sel_price;
                        w_idx_next    = sel_idx;
                        w_state_next  = VEND;
                    end
                end else if ((r_state == CREDIT) && w_tmo_expired) begin
                    w_state_next = (r_credit == '0) ? IDLE : CHANGE;
                end
            end
            VEND: begin
                w_reject = w_coin;
                if (dispense_ack) begin
                    w_state_next = (r_credit == '0) ? IDLE : CHANGE;
                end else if (w_wdog_expired) begin
                    w_credit_next = w_refund_credit;
                    w_fault       = 1'b1;
                    w_state_next  = (w_refund_credit == '0) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                // r_phase low: pay one unit; r_phase high: gap cycle.
                w_reject = w_coin;
                if (!r_phase) begin
                    if (r_credit == '0) begin
                        w_state_next = IDLE;
                    end else begin
                        w_coin_out    = 1'b1;
                        w_credit_next = r_credit - CREDIT_W'(1);
                        w_phase_next  = 1'b1;
                    end
                end else if (r_credit == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        credit       = r_credit;
        insert_coin  = (r_state == CREDIT);
        dispense_req = (r_state == VEND);
        dispense_idx = r_idx;
        coin_out     = r_coin_out;
        coin_reject  = r_reject;
        err_soldout  = r_soldout;
        err_funds    = r_funds;
        fault        = r_fault;
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_vend_controller
// Brief   : Scoreboard bench for vend_controller (expected events queued by
//           stimulus, popped by a negedge monitor). Honours VEND_WDOG_EN.
// Revision: 1.0
// ============================================================================
module tb_vend_controller;

    localparam int EV_REJECT  = 0;
    localparam int EV_SOLDOUT = 1;
    localparam int EV_FUNDS   = 2;
    localparam int EV_COINOUT = 3;
    localparam int EV_DISP    = 4;
    localparam int EV_FAULT   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifty, dollar, cancel, sel_valid, dispense_ack;
    logic [1:0]  sel_idx;
    logic [15:0] price_tbl;
    logic [3:0]  sold_out;
    logic [3:0]  credit;
    logic        insert_coin, dispense_req, coin_out, coin_reject;
    logic        err_soldout, err_funds, fault;
    logic [1:0]  dispense_idx;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    logic prev_req = 1'b0;

    vend_controller #(
        .NUM_ITEMS   (4),
        .CREDIT_W    (4),
        .TIMEOUT_CYC (10),
        .WDOG_CYC    (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifty        (fifty),
        .dollar       (dollar),
        .cancel       (cancel),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .price_tbl    (price_tbl),
        .sold_out     (sold_out),
        .dispense_ack (dispense_ack),
        .credit       (credit),
        .insert_coin  (insert_coin),
        .dispense_req (dispense_req),
        .dispense_idx (dispense_idx),
        .coin_out     (coin_out),
        .coin_reject  (coin_reject),
        .err_soldout  (err_soldout),
        .err_funds    (err_funds),
        .fault        (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input int k, input int d, input int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input int d);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d data %0d at cycle %0d, expected none", k, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d || (e.cyc != 0 && e.cyc != cyc)) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %0d cycle %0d, expected kind %0d data %0d cycle %0d",
                         k, d, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: every output pulse or dispense start consumes one expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (coin_reject) check_ev(EV_REJECT, int'(credit));
            if (err_soldout) check_ev(EV_SOLDOUT, int'(credit));
            if (err_funds) check_ev(EV_FUNDS, int'(credit));
            if (coin_out) check_ev(EV_COINOUT, int'(credit));
            if (dispense_req && !prev_req) check_ev(EV_DISP, int'(dispense_idx));
            if (fault) check_ev(EV_FAULT, int'(credit));
        end
        prev_req = rst ? 1'b0 : dispense_req;
    end

    task automatic apply(input logic f, input logic d, input logic c, input logic s,
                         input logic [1:0] idx, input logic ack);
        fifty = f; dollar = d; cancel = c; sel_valid = s; sel_idx = idx; dispense_ack = ack;
        @(negedge clk);
        fifty = 1'b0; dollar = 1'b0; cancel = 1'b0; sel_valid = 1'b0; sel_idx = 2'd0; dispense_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        rst = 1'b1;
        fifty = 1'b0; dollar = 1'b0; cancel = 1'b0; sel_valid = 1'b0; sel_idx = 2'd0;
        dispense_ack = 1'b0;
        price_tbl = {4'd0, 4'd1, 4'd3, 4'd2};
        sold_out  = 4'b0000;
        idle(3);
        chk("rst_credit", int'(credit), 0);
        chk("rst_dispense_req", int'(dispense_req), 0);
        chk("rst_insert_coin", int'(insert_coin), 0);
        chk("rst_coin_out", int'(coin_out), 0);
        rst = 1'b0;
        idle(1);

        // Exact purchase: item0 costs 2
        apply(0, 1, 0, 0, 2'd0, 0);
        chk("exact_credit", int'(credit), 2);
        chk("exact_insert", int'(insert_coin), 1);
        expect_ev(EV_DISP, 0, cyc + 1);
        apply(0, 0, 0, 1, 2'd0, 0);
        chk("exact_credit_after_sel", int'(credit), 0);
        idle(3);
        chk("exact_req_held", int'(dispense_req), 1);
        chk("exact_idx", int'(dispense_idx), 0);
        apply(0, 0, 0, 0, 2'd0, 1);
        chk("exact_req_drop", int'(dispense_req), 0);
        idle(3);
        chk("exact_idle", int'(insert_coin), 0);
        chk("exact_final_credit", int'(credit), 0);

        // Change: item1 costs 3, pay 4
        apply(0, 1, 0, 0, 2'd0, 0);
        apply(0, 1, 0, 0, 2'd0, 0);
        chk("change_credit4", int'(credit), 4);
        expect_ev(EV_DISP, 1, cyc + 1);
        apply(0, 0, 0, 1, 2'd1, 0);
        chk("change_credit1", int'(credit), 1);
        idle(2);
        expect_ev(EV_COINOUT, 0, cyc + 2);
        apply(0, 0, 0, 0, 2'd0, 1);
        idle(4);
        chk("change_final_credit", int'(credit), 0);
        chk("change_idle", int'(insert_coin), 0);

        // Errors: insufficient funds, then sold out
        apply(1, 0, 0, 0, 2'd0, 0);
        chk("err_credit1", int'(credit), 1);
        expect_ev(EV_FUNDS, 1, cyc + 1);
        apply(0, 0, 0, 1, 2'd1, 0);
        chk("err_funds_credit", int'(credit), 1);
        sold_out = 4'b0100;
        expect_ev(EV_SOLDOUT, 1, cyc + 1);
        apply(0, 0, 0, 1, 2'd2, 0);
        chk("err_soldout_credit", int'(credit), 1);
        chk("err_still_credit_state", int'(insert_coin), 1);
        sold_out = 4'b0000;
        expect_ev(EV_COINOUT, 0, cyc + 2);
        apply(0, 0, 1, 0, 2'd0, 0);
        idle(3);
        chk("err_refund_credit", int'(credit), 0);

        // Overflow: 14 units then a 3-unit insert is bounced, cancel pays 14
        for (int i = 0; i < 7; i++) apply(0, 1, 0, 0, 2'd0, 0);
        chk("ovf_credit14", int'(credit), 14);
        expect_ev(EV_REJECT, 14, cyc + 1);
        apply(1, 1, 0, 0, 2'd0, 0);
        chk("ovf_credit_kept", int'(credit), 14);
        e = cyc + 1;
        for (int k = 0; k < 14; k++) expect_ev(EV_COINOUT, 13 - k, e + 1 + 2 * k);
        apply(0, 0, 1, 0, 2'd0, 0);
        idle(28);
        chk("ovf_final_credit", int'(credit), 0);
        chk("ovf_idle", int'(insert_coin), 0);

        // Timeout after 10 idle cycles in CREDIT
        e = cyc + 1;
        expect_ev(EV_COINOUT, 0, e + 11);
        apply(1, 0, 0, 0, 2'd0, 0);
        idle(9);
        chk("tmo_still_credit", int'(insert_coin), 1);
        idle(1);
        chk("tmo_left_credit", int'(insert_coin), 0);
        idle(4);
        chk("tmo_final_credit", int'(credit), 0);

        // A coin on idle cycle 9 restarts the count
        e = cyc + 1;
        expect_ev(EV_COINOUT, 1, e + 20);
        expect_ev(EV_COINOUT, 0, e + 22);
        apply(1, 0, 0, 0, 2'd0, 0);
        idle(8);
        apply(1, 0, 0, 0, 2'd0, 0);
        chk("tmo_restart_credit", int'(credit), 2);
        idle(9);
        chk("tmo_restart_held", int'(insert_coin), 1);
        idle(6);
        chk("tmo_restart_final", int'(credit), 0);
        chk("tmo_restart_idle", int'(insert_coin), 0);

        // Asynchronous reset mid-VEND
        apply(0, 1, 0, 0, 2'd0, 0);
        apply(0, 1, 0, 0, 2'd0, 0);
        expect_ev(EV_DISP, 0, cyc + 1);
        apply(0, 0, 0, 1, 2'd0, 0);
        chk("arst_in_vend", int'(dispense_req), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", int'(dispense_req), 0);
        chk("arst_credit", int'(credit), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        chk("arst_stays_idle", int'(dispense_req), 0);

`ifdef VEND_WDOG_EN
        // Watchdog: no ack for 20 cycles refunds item0's price
        apply(0, 1, 0, 0, 2'd0, 0);
        e = cyc + 1;
        expect_ev(EV_DISP, 0, e);
        expect_ev(EV_FAULT, 2, e + 20);
        expect_ev(EV_COINOUT, 1, e + 21);
        expect_ev(EV_COINOUT, 0, e + 23);
        apply(0, 0, 0, 1, 2'd0, 0);
        idle(19);
        chk("wdog_req_held", int'(dispense_req), 1);
        idle(1);
        chk("wdog_req_drop", int'(dispense_req), 0);
        chk("wdog_refund", int'(credit), 2);
        idle(5);
        chk("wdog_final_credit", int'(credit), 0);
`endif

        idle(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Multi-item vending sequencer built around the coin-credit FSM concept.
- Accumulates credit from 50c/$1 pulses and validates item selection against a runtime price table.
- Drives a shared dispense mechanism through a req/ack handshake, then pays change as a train of 50c coin_out pulses.
- Sits between the coin acceptor/keypad inputs and the dispense/coin-return actuators.

Parameters:
- NUM_ITEMS, 4, number of selectable items.
- CREDIT_W, 4, credit width in 50c units; max credit is 2^CREDIT_W-1 (15 = $7.50).
- TIMEOUT_CYC, 1000, idle cycles in CREDIT before automatic refund.
- WDOG_CYC, 255, dispense_ack watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifty  in  1  one-cycle pulse: 50c inserted (1 unit).
- dollar  in  1  one-cycle pulse: $1 inserted (2 units).
- cancel  in  1  one-cycle pulse: refund request.
- sel_valid  in  1  one-cycle pulse: selection strobe.
- sel_idx  in  $clog2(NUM_ITEMS)  selected item, sampled with sel_valid.
- price_tbl  in  NUM_ITEMS*CREDIT_W  packed per-item price in units; item i at [i*CREDIT_W +: CREDIT_W]; quasi-static.
- sold_out  in  NUM_ITEMS  per-item empty flag.
- dispense_ack  in  1  mechanism done; one-cycle pulse.
- credit  out  CREDIT_W  current credit in units.
- insert_coin  out  1  high in CREDIT.
- dispense_req  out  1  high throughout VEND.
- dispense_idx  out  $clog2(NUM_ITEMS)  item being vended; stable while dispense_req is high.
- coin_out  out  1  one-cycle pulse per 50c returned.
- coin_reject  out  1  one-cycle pulse: the inserted coin is bounced.
- err_soldout  out  1  one-cycle pulse.
- err_funds  out  1  one-cycle pulse.
- fault  out  1  one-cycle pulse (optional feature only).

Behaviour:
- Outputs and reset:
  - All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
  - Reset forces state IDLE and drives every output and the credit to 0. Reset asserted mid-operation forfeits credit and drops dispense_req immediately.
- State machine: IDLE, CREDIT, VEND, CHANGE.
- Coin acceptance (IDLE/CREDIT):
  - A coin pulse sampled at edge N updates credit visible from cycle N+1 and moves IDLE to CREDIT.
  - fifty and dollar in the same cycle count as 3 units.
  - If the sum would exceed the max credit, all coins that cycle are rejected: coin_reject pulses at N+1 and credit is unchanged.
- Coins in VEND/CHANGE are always rejected with a coin_reject pulse.
- Selection (IDLE/CREDIT, sel_valid with no coin and no cancel in the same cycle):
  - If sold_out[sel_idx] is set: err_soldout pulses and state is unchanged.
  - Otherwise, if credit < price: err_funds pulses and state is unchanged.
  - Otherwise: credit -= price, dispense_idx <= sel_idx, next state VEND.
- Priority in one cycle: coin accepted first, then cancel, then selection. sel_valid is ignored if a coin or cancel is present.
- Cancel:
  - In CREDIT, moves to CHANGE.
  - In IDLE, no effect.
  - In VEND or CHANGE, ignored.
- VEND:
  - dispense_req is held high until dispense_ack.
  - On ack, next state is CHANGE if credit > 0, else IDLE. dispense_req is low the cycle after ack.
- CHANGE:
  - Alternating cycles: coin_out high one cycle, then low one cycle; credit decrements by 1 with each pulse.
  - When credit reaches 0, returns to IDLE. Payout of N units takes 2N cycles.
  - Entering CHANGE with credit = 0 goes directly to IDLE.
- Inactivity timeout:
  - The counter reloads on any accepted coin, rejected selection or state entry into CREDIT.
  - Expiry after TIMEOUT_CYC consecutive idle cycles in CREDIT moves to CHANGE (full refund).
- Credit arithmetic is unsigned CREDIT_W bits, and credit never wraps. A price of 0 vends free.

Optional Feature:
- VEND_WDOG_EN:
  - When defined, a watchdog counts cycles in VEND.
  - If dispense_ack is absent for WDOG_CYC cycles: dispense_req drops, the item price is added back to credit (saturating), fault pulses once, and next state is CHANGE.
  - When undefined, VEND waits indefinitely, the fault output is tied 0 and WDOG_CYC is unused.

Decomposition:
- Package vend_pkg:
  - state encoding IDLE=0, CREDIT=1, VEND=2, CHANGE=3;
  - unit constants UNIT_FIFTY=1, UNIT_DOLLAR=2.
- Sub-module vend_timer: loadable down-counter with load, enable and expired outputs. It is instantiated once for the inactivity timeout and once more for the watchdog when VEND_WDOG_EN is defined.

Test Plan:
- Exact purchase, price_tbl item0=2: dollar, then sel_valid idx0 → dispense_req/dispense_idx=0 until ack; after ack, IDLE and credit=0 with no coin_out.
- Change, item1=3: dollar, dollar, sel idx1 → credit 4→1; after ack, one coin_out pulse and credit=0.
- Errors: fifty then sel idx1 (price 3) → err_funds, credit stays 1; sold_out[2]=1 with sel idx2 → err_soldout.
- Overflow: seven dollars → credit=14; fifty+dollar in the same cycle → coin_reject and credit stays 14; then cancel → 14 coin_out pulses over 28 cycles.
- Timeout, TIMEOUT_CYC=10: fifty then 10 idle cycles → CHANGE and one coin_out; a coin at cycle 9 restarts the count.
- Reset during VEND with async rst mid-cycle → dispense_req=0 and credit=0 before the next edge. With VEND_WDOG_EN: no ack for WDOG_CYC cycles → fault, price refunded and paid out.
